// File: rtl/wallace_mul_arbiter.sv
// +----------------------------------------------------------------------+
// | wallace_mul_arbiter: round-robin sharing of one 4x4 Wallace multiplier |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fourwalmul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);
  logic [3:0] pp [4];

  // pp[i][j] = a[i] & b[j], weight i+j
  for (genvar i = 0; i < 4; i++) begin : g_pp_row
    assign pp[i] = b & {4{a[i]}};
  end

  logic s3a, c3a, s4a, c4a;
  logic s2b, c2b, s3b, c3b, s4b, c4b, s5b, c5b;

  assign s3a = pp[3][0] ^ pp[2][1];
  assign c3a = pp[3][0] & pp[2][1];
  assign s4a = pp[3][1] ^ pp[2][2];
  assign c4a = pp[3][1] & pp[2][2];

  assign s2b = pp[2][0] ^ pp[1][1];
  assign c2b = pp[2][0] & pp[1][1];
  assign s3b = s3a ^ pp[1][2] ^ pp[0][3];
  assign c3b = (s3a & pp[1][2]) | (pp[0][3] & (s3a ^ pp[1][2]));
  assign s4b = s4a ^ pp[1][3] ^ c3a;
  assign c4b = (s4a & pp[1][3]) | (c3a & (s4a ^ pp[1][3]));
  assign s5b = pp[3][2] ^ pp[2][3] ^ c4a;
  assign c5b = (pp[3][2] & pp[2][3]) | (c4a & (pp[3][2] ^ pp[2][3]));

  logic [7:0] row_a, row_b;
  assign row_a = {1'b0, pp[3][3], s5b, s4b, s3b, s2b, pp[1][0], pp[0][0]};
  assign row_b = {1'b0, c5b, c4b, c3b, c2b, pp[0][2], pp[0][1], 1'b0};
  assign prod  = row_a + row_b;
endmodule

module wallace_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_mp,
  input  logic [4*NREQ-1:0] req_ml,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_prod,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [3:0]      mp_q, mp_d, ml_q, ml_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [7:0]      rsp_prod_q, rsp_prod_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic [7:0]      prod;

  fourwalmul u_mul (
    .a    (mp_q),
    .b    (ml_q),
    .prod (prod)
  );

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   rr_sum;

  // Search upward from the requester after the last one served, wrapping at NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (rr_sum >= (IDW+1)'(NREQ)) rr_sum = rr_sum - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[rr_sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mp_d         = mp_q;
    ml_d         = ml_q;
    id_d         = id_q;
    rsp_prod_d   = rsp_prod_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          mp_d         = req_mp[{grant_idx, 2'b00} +: 4];
          ml_d         = req_ml[{grant_idx, 2'b00} +: 4];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = MUL;
        end
      end
      MUL: begin
        rsp_prod_d = prod;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = (&op_count_q) ? op_count_q : op_count_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ-1);
      mp_q         <= '0;
      ml_q         <= '0;
      id_q         <= '0;
      rsp_prod_q   <= '0;
      rsp_id_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mp_q         <= mp_d;
      ml_q         <= ml_d;
      id_q         <= id_d;
      rsp_prod_q   <= rsp_prod_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_prod  = rsp_prod_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
endmodule

`default_nettype wire

// File: tb/tb_wallace_mul_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_wallace_mul_arbiter: directed bench for wallace_mul_arbiter       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wallace_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_mp;
  logic [4*NREQ-1:0] req_ml;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_prod;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  wallace_mul_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mp    (req_mp),
    .req_ml    (req_ml),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] mp, input logic [3:0] ml);
    req_valid[id]      = 1'b1;
    req_mp[4*id +: 4] = mp;
    req_ml[4*id +: 4] = ml;
  endtask

  // Waits (bounded) on negedges for rsp_valid; returns the presented response
  task automatic wait_rsp(output logic [7:0] p, output logic [IDW-1:0] id, output int at);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else n++;
    end
    p  = rsp_prod;
    id = rsp_id;
    at = cyc;
    check("rsp_timeout", 32'(seen), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]     p;
    logic [IDW-1:0] id;
    int             at;
    int             prev_at;
    int             exp_id [5]   = '{0, 1, 2, 3, 0};
    int             exp_prod [5] = '{2, 16, 81, 225, 2};

    req_valid = '0;
    req_mp    = '0;
    req_ml    = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    prev_at   = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_prod", 32'(rsp_prod), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(op_count), 0);
    rst_n = 1'b1;

    // Single request from requester 2
    @(negedge clk);
    set_req(2, 4'd3, 4'd5);
    #1 check("single_ready", 32'(req_ready), 4);
    @(negedge clk);
    req_valid = '0;
    check("single_ready_mul", 32'(req_ready), 0);
    check("single_busy_mul", 32'(busy), 1);
    check("single_valid_mul", 32'(rsp_valid), 0);
    @(negedge clk);
    check("single_valid", 32'(rsp_valid), 1);
    check("single_prod", 32'(rsp_prod), 15);
    check("single_id", 32'(rsp_id), 2);
    @(negedge clk);
    check("single_count", 32'(op_count), 1);
    check("single_valid_done", 32'(rsp_valid), 0);
    check("single_busy_done", 32'(busy), 0);

    // Asynchronous reset while in MUL after granting requester 1
    @(negedge clk);
    set_req(1, 4'd2, 4'd2);
    #1 check("rmul_ready", 32'(req_ready), 2);
    @(negedge clk);
    req_valid = '0;
    check("rmul_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmul_busy_rst", 32'(busy), 0);
    check("rmul_valid_rst", 32'(rsp_valid), 0);
    check("rmul_prod_rst", 32'(rsp_prod), 0);
    check("rmul_id_rst", 32'(rsp_id), 0);
    check("rmul_count_rst", 32'(op_count), 0);
    check("rmul_ready_rst", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention: requester 0 first after reset, then strict rotation
    @(negedge clk);
    set_req(0, 4'd1, 4'd2);
    set_req(1, 4'd4, 4'd4);
    set_req(2, 4'd9, 4'd9);
    set_req(3, 4'd15, 4'd15);
    #1 check("cont_first_ready", 32'(req_ready), 1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(p, id, at);
      check("cont_id", 32'(id), 32'(exp_id[i]));
      check("cont_prod", 32'(p), 32'(exp_prod[i]));
      if (i > 0) check("cont_spacing", 32'(at - prev_at), 3);
      prev_at = at;
      @(posedge clk);
    end
    req_valid = '0;

    // Backpressure on 11x11 with another requester waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 4'd11, 4'd11);
    #1 check("bp_ready", 32'(req_ready), 2);
    @(negedge clk);
    req_valid = 4'b1000;
    wait_rsp(p, id, at);
    check("bp_prod0", 32'(p), 121);
    check("bp_id0", 32'(id), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_prod", 32'(rsp_prod), 121);
      check("bp_id", 32'(rsp_id), 1);
      check("bp_ready_hold", 32'(req_ready), 0);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_count", 32'(op_count), 5);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("bp_count_done", 32'(op_count), 6);
    check("bp_valid_done", 32'(rsp_valid), 0);
    check("bp_busy_done", 32'(busy), 0);
    @(negedge clk);
    check("bp_count_single", 32'(op_count), 6);

    // Valid pulse during RESP must not produce a grant
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 4'd7, 4'd3);
    #1 check("drop_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(p, id, at);
    check("drop_prod", 32'(p), 21);
    check("drop_id", 32'(id), 0);
    req_valid = 4'b0100;
    #1 check("drop_ready_resp", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("idle_busy", 32'(busy), 0);
      check("idle_ready", 32'(req_ready), 0);
      check("idle_valid", 32'(rsp_valid), 0);
      @(negedge clk);
    end
    check("drop_count", 32'(op_count), 7);

    // Exhaustive operand sweep on requester 1
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int mp = 0; mp < 16; mp++) begin
      for (int ml = 0; ml < 16; ml++) begin
        @(negedge clk);
        set_req(1, 4'(mp), 4'(ml));
        #1 check("sweep_ready", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(p, id, at);
        check("sweep_prod", 32'(p), 32'(mp * ml));
        check("sweep_id", 32'(id), 1);
        @(posedge clk);
      end
    end
    @(negedge clk);
    check("sweep_count", 32'(op_count), 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Round-robin arbiter and sequencer that shares one 4x4 Wallace tree multiplier (`fourwalmul`, instantiated inside this block) among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, registers its operands into the multiplier, and captures the 8-bit product. It returns the product with the requester ID over a valid/ready response channel that supports backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- CNTW, 16, width of the completed-operation counter

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  bit i: requester i offers an operand pair
- req_ready  out  NREQ  one-hot or zero; bit i: requester i's pair is accepted this cycle
- req_mp  in  4*NREQ  multiplicand of requester i in bits [4i+3:4i]
- req_ml  in  4*NREQ  multiplier of requester i in bits [4i+3:4i]
- rsp_valid  out  1  a result is presented
- rsp_ready  in  1  the consumer accepts the result
- rsp_prod  out  8  unsigned product mp*ml
- rsp_id  out  IDW  index of the requester that owns rsp_prod
- busy  out  1  high in any state other than IDLE
- op_count  out  CNTW  number of completed responses; saturates at all-ones

## Operation
- FSM states: IDLE, MUL, RESP. Reset enters IDLE.
- IDLE:
  - If no req_valid bit is set: stay in IDLE, req_ready = 0.
  - Otherwise grant g = the first requester with valid set, searching upward from (last_grant+1) mod NREQ.
  - req_ready[g] = 1 combinationally in the same cycle. It is the only ready bit set.
  - On that edge: capture mp_q <= req_mp[g], ml_q <= req_ml[g], id_q <= g, last_grant <= g. Go to MUL.
- MUL:
  - mp_q and ml_q drive `fourwalmul`.
  - On the next edge: rsp_prod_q <= prod, rsp_id_q <= id_q. Go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_prod and rsp_id are held stable until the handshake completes.
  - When rsp_valid && rsp_ready: increment op_count (saturating) and go to IDLE.
  - While in RESP, req_ready stays 0 for every requester.
- Arithmetic:
  - Operands are unsigned 4-bit.
  - The product is the full 8 bits, 0..225. There is no truncation or overflow.
- Fairness:
  - A requester that was just served has the lowest priority at the next grant.
  - With all requesters valid, the grant order is 0,1,...,NREQ-1,0,...
- Requester rule: req_valid may drop without a handshake. A requester is granted only if its valid bit is high in the IDLE cycle.
- req_valid changing while the block is in MUL or RESP has no effect.

## Timing
- Reset values:
  - state = IDLE, last_grant = NREQ-1 (so requester 0 wins first)
  - req_ready = 0, rsp_valid = 0, rsp_prod = 0, rsp_id = 0
  - busy = 0, op_count = 0
- Latency:
  - Request accepted at edge T.
  - rsp_valid is high from after edge T+1.
  - The earliest response handshake is at edge T+2.
  - The earliest next grant is at edge T+3.
- Peak throughput: one operation per 3 cycles when rsp_ready is held high.
- Backpressure: rsp_ready low holds the block in RESP indefinitely, with outputs frozen.
- Asynchronous reset mid-operation (MUL or RESP):
  - Immediately return to IDLE and drop rsp_valid.
  - The in-flight result is discarded, and op_count is cleared.
- op_count at all-ones stays at all-ones on further completions.
- busy equals (state != IDLE), combinationally.

## Test plan
- Single request: requester 2 sends mp=3, ml=5, rsp_ready=1.
  - req_ready = 4'b0100 for one cycle.
  - Two edges later: rsp_valid=1, rsp_prod=15, rsp_id=2. op_count becomes 1.
- Full contention: all 4 requesters valid continuously with pairs (1,2), (4,4), (9,9), (15,15).
  - Responses arrive in order id 0,1,2,3 with products 2, 16, 81, 225, then the order wraps to id 0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises on 11x11.
  - rsp_prod stays at 121 and rsp_id stays stable.
  - req_ready stays 0.
  - A single completion occurs when rsp_ready goes to 1.
- Reset in MUL: drop rst_n one cycle after a grant.
  - All outputs take their reset values asynchronously.
  - After release, requester 0 has priority again.
- Exhaustive sweep: one requester steps through all 256 (mp,ml) pairs.
  - Every rsp_prod equals mp*ml.
  - Final op_count = 256.
- Idle and drop-out: req_valid pulses and drops while the block is in RESP.
  - No grant results from it.
  - With no valid requests, busy stays 0 and req_ready stays 0.
